uart_rx: RTL and testbench

Serial receiver for the UART link. It recovers framed characters from the `RxD` line using mid-bit sampling, then checks even parity, the stop bit and overrun. Each received character goes out on a valid/ready word interface with per-character error flags. It sits in the `rx_clk` domain of the `uart` top, on the far end of the line driven by the transmitter.

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, even parity / stop / overrun checks.
// Word is valid one cycle after the stop sample; a new frame arriving while valid is held is dropped with an overrun pulse.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  rx_clk,
    input  logic                  reset,
    input  logic                  RxD,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t                state, state_nxt;
    logic                  rx_meta, rxs, rxs_d;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic                  tick, cnt_clr, sample, par_sample, done, counting;

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Start bit is sampled after half a bit; every later bit one full bit time after the previous sample.
    assign tick     = (cnt == ((state == START) ? HALF_LAST : CPB_LAST));
    assign counting = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign busy     = (state != IDLE);

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        sample     = 1'b0;
        par_sample = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    sample  = 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_clr    = 1'b1;
                    par_sample = 1'b1;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_clr   = 1'b1;
                    done      = 1'b1;
                    state_nxt = rxs ? IDLE : BRK;
                end
            end
            BRK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            if (cnt_clr)       cnt <= '0;
            else if (counting) cnt <= cnt + CW'(1);

            if (state == START)  bit_cnt <= '0;
            else if (sample)     bit_cnt <= bit_cnt + BW'(1);

            if (sample) shreg <= {rxs, shreg[DATA_WIDTH-1:1]};

            if (par_sample) par_bad <= (PARITY_EN != 0) && ((^shreg) ^ rxs);
        end
    end

    // Completion coinciding with an accept is a free slot, so the new word replaces the old one.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            data        <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data       <= shreg;
                    parity_err <= (PARITY_EN != 0) && par_bad;
                    frame_err  <= !rxs;
                    valid      <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters: clean, parity error, break, glitch, overrun, mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    int         cyc      = 0;
    int         fall_cyc = 0;
    int         n_words  = 0;
    int         n_ovr    = 0;
    int         word_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_pe   = 1'b0;
    logic       last_fe   = 1'b0;

    uart_rx dut (
        .rx_clk      (clk),
        .reset       (rst_n),
        .RxD         (rxd),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted words and overrun pulses away from the active edge.
    always @(negedge clk) begin
        if (valid && ready) begin
            n_words   <= n_words + 1;
            last_data <= data;
            last_pe   <= parity_err;
            last_fe   <= frame_err;
            word_cyc  <= cyc;
        end
        if (overrun_err) n_ovr <= n_ovr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    int base_w;
    int base_o;

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",    32'(data), 32'h00);
        check("rst_valid",   32'(valid), 32'd0);
        check("rst_pe",      32'(parity_err), 32'd0);
        check("rst_fe",      32'(frame_err), 32'd0);
        check("rst_ovr",     32'(overrun_err), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 'E', checked for exact latency from falling edge to valid.
        base_w = n_words; base_o = n_ovr;
        send_frame(8'h45, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("e_words", 32'(n_words - base_w), 32'd1);
        check("e_data",  32'(last_data), 32'h45);
        check("e_pe",    32'(last_pe), 32'd0);
        check("e_fe",    32'(last_fe), 32'd0);
        check("e_ovr",   32'(n_ovr - base_o), 32'd0);
        check("e_lat",   32'(word_cyc - fall_cyc), 32'd4560);

        // Parity bit forced to 0.
        base_w = n_words;
        send_frame(8'h45, 1'b0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("par_words", 32'(n_words - base_w), 32'd1);
        check("par_data",  32'(last_data), 32'h45);
        check("par_pe",    32'(last_pe), 32'd1);
        check("par_fe",    32'(last_fe), 32'd0);

        // Stop bit 0 followed by a 20-bit break.
        base_w = n_words;
        send_frame(8'h45, 1'b1, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        check("brk_busy_held", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("brk_busy_rel", 32'(busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check("brk_words", 32'(n_words - base_w), 32'd1);
        check("brk_data",  32'(last_data), 32'h45);
        check("brk_fe",    32'(last_fe), 32'd1);
        check("brk_pe",    32'(last_pe), 32'd0);

        // 100-cycle low glitch: start check at HALF rejects it.
        base_w = n_words;
        fall_cyc = cyc;
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (119) @(negedge clk);
        check("gl_busy_219", 32'(busy), 32'd1);
        @(negedge clk);
        check("gl_busy_220", 32'(busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check("gl_words", 32'(n_words - base_w), 32'd0);

        // Overrun with the consumer stalled.
        base_w = n_words; base_o = n_ovr;
        ready = 1'b0;
        send_frame(8'h4E, 1'b0, 1'b1);
        send_frame(8'h52, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_data",  32'(data), 32'h4E);
        check("ovr_pulse", 32'(n_ovr - base_o), 32'd1);
        ready = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("ovr_drain", 32'(n_words - base_w), 32'd1);
        check("ovr_ddata", 32'(last_data), 32'h4E);
        check("ovr_empty", 32'(valid), 32'd0);

        // Reset mid data bit 3 of 0x51, then a clean 0x55.
        base_w = n_words;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("ab_busy",  32'(busy), 32'd0);
        check("ab_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("ab_nowords", 32'(n_words - base_w), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("ab_words", 32'(n_words - base_w), 32'd1);
        check("ab_data",  32'(last_data), 32'h55);
        check("ab_pe",    32'(last_pe), 32'd0);
        check("ab_fe",    32'(last_fe), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
